// File: rtl/ivd_pkg.sv
// Shared types and constants for the IVD assay scheduler.
package ivd_pkg;

   localparam int IVD_NCH = 6;
   localparam int IVD_CW  = 3;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      LOAD,
      MIX,
      DETECT,
      REPORT,
      FINISH
   } ivd_state_e;

   // Counter width able to hold the largest phase length minus one.
   function automatic int ivd_timer_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/ivd_phase_timer.sv
// Loadable down-counter shared by the LOAD, MIX and detector-timeout phases.
// Holds at zero until reloaded; zero flags the last cycle of a phase.
module ivd_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         cnt <= '0;
      else if (load)      cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ivd_assay_scheduler.sv
// Sequences the assay channels one at a time: LOAD -> MIX -> DETECT -> REPORT.
// Optional detector ack timeout is enabled by defining IVD_DET_TIMEOUT_EN.
module ivd_assay_scheduler
   import ivd_pkg::*;
#(
   parameter int NCH         = IVD_NCH,
   parameter int LOAD_CYCLES = 16,
   parameter int MIX_CYCLES  = 64,
   parameter int DW          = 12,
   parameter int TMO_CYCLES  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [NCH-1:0]    chan_mask,
   output logic              busy,
   output logic              done,
   output logic [NCH-1:0]    sample_valve,
   output logic [NCH-1:0]    reagent_valve,
   output logic [NCH-1:0]    mix_en,
   output logic              det_req,
   output logic [IVD_CW-1:0] det_chan,
   input  logic              det_ack,
   input  logic [DW-1:0]     det_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IVD_CW-1:0] res_chan,
   output logic [DW-1:0]     res_data,
   output logic              res_err,
   output ivd_state_e        dbg_state
);

   localparam int TW = ivd_timer_width(LOAD_CYCLES, MIX_CYCLES, TMO_CYCLES);
   localparam logic [TW-1:0] LOAD_LD = TW'(LOAD_CYCLES - 1);
   localparam logic [TW-1:0] MIX_LD  = TW'(MIX_CYCLES - 1);
`ifdef IVD_DET_TIMEOUT_EN
   localparam logic [TW-1:0] TMO_LD  = TW'(TMO_CYCLES - 1);
`endif

   ivd_state_e        state, state_n;
   logic [NCH-1:0]    pend;
   logic [IVD_CW-1:0] chan, chan_n, enc;
   logic [NCH-1:0]    enc_oh, chan_oh;
   logic              aborting;
   logic              tmr_load, tmr_zero;
   logic [TW-1:0]     tmr_val;

   // Handshakes: det_req/det_ack and res_valid/res_ready are valid/ready pairs; a
   // transfer happens on the clock edge where both are high, and the requester holds
   // its signals (det_chan, res_chan, res_data) stable until that edge.

   always_comb begin
      enc = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (pend[i]) enc = IVD_CW'(i);
   end

   assign enc_oh   = {{(NCH-1){1'b0}}, 1'b1} << enc;
   assign chan_n   = (state == SELECT) ? enc : chan;
   assign chan_oh  = {{(NCH-1){1'b0}}, 1'b1} << chan_n;
   assign aborting = abort && (state != IDLE);

   ivd_phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (aborting) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_n = SELECT;
            SELECT:  state_n = (pend == '0) ? FINISH : LOAD;
            LOAD:    if (tmr_zero) state_n = MIX;
            MIX:     if (tmr_zero) state_n = DETECT;
            DETECT: begin
               if (det_ack) state_n = REPORT;
`ifdef IVD_DET_TIMEOUT_EN
               else if (tmr_zero) state_n = REPORT;
`endif
            end
            REPORT:  if (res_ready) state_n = SELECT;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Each timed phase reloads the timer on the edge that enters it.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         SELECT: begin
            tmr_load = 1'b1;
            tmr_val  = LOAD_LD;
         end
         LOAD: if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = MIX_LD;
         end
`ifdef IVD_DET_TIMEOUT_EN
         MIX: if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
         end
`endif
         default: ;
      endcase
   end

   // Actuator outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend          <= '0;
         chan          <= '0;
         sample_valve  <= '0;
         reagent_valve <= '0;
         mix_en        <= '0;
         det_req       <= 1'b0;
         det_chan      <= '0;
         res_valid     <= 1'b0;
         res_chan      <= '0;
         res_data      <= '0;
         done          <= 1'b0;
      end else begin
         sample_valve  <= (state_n == LOAD) ? chan_oh : '0;
         reagent_valve <= (state_n == LOAD) ? chan_oh : '0;
         mix_en        <= (state_n == MIX)  ? chan_oh : '0;
         det_req       <= (state_n == DETECT);
         res_valid     <= (state_n == REPORT);
         done          <= (state != IDLE) && (state_n == IDLE);
         chan          <= chan_n;
         if (state_n == DETECT) det_chan <= chan_n;
         if (state == DETECT && state_n == REPORT) begin
            res_chan <= chan;
            res_data <= det_ack ? det_data : '0;
         end
         if (aborting)                 pend <= '0;
         else if (state == IDLE && start) pend <= chan_mask;
         else if (state == SELECT)     pend <= pend & ~enc_oh;
      end
   end

`ifdef IVD_DET_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                res_err <= 1'b0;
      else if (state == DETECT && state_n == REPORT) res_err <= !det_ack;
   end
`else
   assign res_err = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
